// File: rtl/npc_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : npc_axi_pkg                                                      |
// | Purpose : Shared AXI encodings, responder state type and a burst-legality  |
// |           helper, shared by the read responder and its address helper.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package npc_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_MEM  = 2'd2,
    RD_RESP = 2'd3
  } rd_state_t;

  // A burst is serviceable when the beat size fits the 32-bit bus, the burst
  // type is not reserved, and WRAP bursts use one of the AXI wrap lengths.
  function automatic logic burst_legal(input logic [2:0] size,
                                       input logic [7:0] len,
                                       input logic [1:0] burst);
    logic ok;
    ok = (size <= 3'd2) && (burst != 2'b11);
    if (burst == AXI_BURST_WRAP)
      ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_rd_responder_if                                              |
// | Purpose : AXI4 read address (AR) and read data (R) channel bundle.         |
// | Ports   : arvalid/arready/araddr/arid/arlen/arsize/arburst (AR channel),   |
// |           rvalid/rready/rdata/rresp/rlast/rid (R channel).                 |
// |           master modport = requester, slave modport = responder.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface axi_rd_responder_if;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_burst_addr                                                   |
// | Purpose : Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.  |
// | Ports   : i_addr  current beat byte address                                |
// |           i_size  log2 bytes per beat                                      |
// |           i_len   beats-1                                                  |
// |           i_burst burst type                                               |
// |           o_next_addr address of the following beat                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_burst_addr
  import npc_axi_pkg::*;
(
  input  wire logic [31:0] i_addr,
  input  wire logic [2:0]  i_size,
  input  wire logic [7:0]  i_len,
  input  wire logic [1:0]  i_burst,
  output logic      [31:0] o_next_addr
);

  logic [31:0] w_bytes;
  logic [31:0] w_incr;
  logic [31:0] w_wrap_mask;

  assign w_bytes     = 32'd1 << i_size;
  assign w_incr      = i_addr + w_bytes;
  // Wrap container is bytes-per-beat * beat count; only its low bits move.
  assign w_wrap_mask = (({24'd0, i_len} + 32'd1) << i_size) - 32'd1;

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr = i_addr;
      AXI_BURST_INCR:  o_next_addr = w_incr;
      AXI_BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:         o_next_addr = w_incr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_rd_responder                                                 |
// | Purpose : AXI4 read slave. One AR at a time, fixed first-beat latency,     |
// |           arlen+1 beats fetched from a 1-cycle synchronous word memory.    |
// |           Every beat is range checked; illegal bursts answer SLVERR.       |
// | Ports   : clk, rst      clock, synchronous active-high reset               |
// |           axi          AR/R channels (slave modport)                      |
// |           mem_en       memory read strobe                                  |
// |           mem_addr     word-aligned byte address                           |
// |           mem_rdata    read data, valid the cycle after mem_en             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_rd_responder
  import npc_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0800_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  axi_rd_responder_if.slave axi,
  output logic             mem_en,
  output logic [31:0]      mem_addr,
  input  wire logic [31:0] mem_rdata
);

  rd_state_t   r_state;
  rd_state_t   w_state_next;

  logic [31:0] r_addr;
  logic [3:0]  r_id;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_slverr;
  logic [7:0]  r_count;
  logic [3:0]  r_delay;
  logic [31:0] r_rdata;
  logic        r_fresh;
  logic [1:0]  r_rresp;
  logic        r_rlast;

  logic [31:0] w_next_addr;
  logic        w_in_range;
  logic        w_beat_ok;
  logic        w_arready;
  logic        w_rvalid;
  logic        w_mem_en;

  axi_burst_addr u_burst_addr (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Subtraction keeps the window check correct even when BASE+BYTES overflows.
  assign w_in_range = (r_addr >= ADDR_BASE) && ((r_addr - ADDR_BASE) < MEM_BYTES);
  assign w_beat_ok  = !r_slverr && w_in_range;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    w_mem_en     = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_arready = 1'b1;
        if (axi.arvalid) w_state_next = (LATENCY == 0) ? RD_MEM : RD_WAIT;
      end
      RD_WAIT: begin
        if (r_delay == 4'd0) w_state_next = RD_MEM;
      end
      RD_MEM: begin
        w_mem_en     = w_beat_ok;
        w_state_next = RD_RESP;
      end
      RD_RESP: begin
        w_rvalid = 1'b1;
        if (axi.rready) w_state_next = r_rlast ? RD_IDLE : RD_MEM;
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_slverr <= 1'b0;
      r_count  <= '0;
      r_delay  <= '0;
      r_rdata  <= '0;
      r_fresh  <= 1'b0;
      r_rresp  <= AXI_RESP_OKAY;
      r_rlast  <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (axi.arvalid) begin
            r_addr   <= axi.araddr;
            r_id     <= axi.arid;
            r_len    <= axi.arlen;
            r_size   <= axi.arsize;
            r_burst  <= axi.arburst;
            r_slverr <= !burst_legal(axi.arsize, axi.arlen, axi.arburst);
            r_count  <= '0;
            r_delay  <= 4'(LATENCY);
          end
        end
        RD_WAIT: begin
          if (r_delay != 4'd0) r_delay <= r_delay - 4'd1;
        end
        RD_MEM: begin
          r_rresp <= r_slverr ? AXI_RESP_SLVERR :
                     (w_in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR);
          r_rlast <= (r_count == r_len);
          // Error beats return zero; good beats overwrite it once the memory answers.
          r_rdata <= '0;
          r_fresh <= w_beat_ok;
        end
        RD_RESP: begin
          if (r_fresh) begin
            r_rdata <= mem_rdata;
            r_fresh <= 1'b0;
          end
          if (axi.rready) begin
            r_rlast <= 1'b0;
            if (!r_rlast) begin
              r_addr  <= w_next_addr;
              r_count <= r_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory data arrives in the first RESP cycle: pass it through then, and
  // serve the captured copy for any later backpressured cycles.
  assign axi.rdata   = r_fresh ? mem_rdata : r_rdata;
  assign axi.arready = w_arready;
  assign axi.rvalid  = w_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rlast   = r_rlast;
  assign axi.rid     = r_id;
  assign mem_en      = w_mem_en;
  assign mem_addr    = {r_addr[31:2], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_axi_rd_responder                                              |
// | Purpose : Scoreboard bench for axi_rd_responder: directed and random AR    |
// |           bursts against a burst-arithmetic reference model.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_axi_rd_responder;
  import npc_axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] BYTES = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;

  axi_rd_responder_if axi();

  axi_rd_responder #(
    .ADDR_BASE (BASE),
    .MEM_BYTES (BYTES),
    .LATENCY   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] maddr_q[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          beats_seen = 0;
  int          rdy_mode   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Synchronous memory: one cycle read latency.
  always @(posedge clk) if (mem_en) mem_rdata <= memf(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Reference model: beat address i from burst arithmetic on the whole burst.
  task automatic push_expected(input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    longint unsigned bytes, total, lower, a;
    bit    legal;
    beat_t b;
    bytes = 64'd1 << size;
    total = bytes * (longint'(len) + 1);
    legal = (size <= 2) && (burst != 2'b11) &&
            !(burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'b00)      a = addr;
      else if (burst == 2'b10) begin
        lower = addr - (addr % total);
        a = lower + (((addr - lower) + i * bytes) % total);
      end
      else a = (addr + i * bytes) % (64'd1 << 32);
      b.id   = id;
      b.last = (i == int'(len));
      if (!legal) begin
        b.resp = 2'b10; b.data = 32'd0;
      end else if (a >= BASE && a < (longint'(BASE) + longint'(BYTES))) begin
        b.resp = 2'b00; b.data = memf(32'(a) & ~32'd3);
        maddr_q.push_back(32'(a) & ~32'd3);
      end else begin
        b.resp = 2'b11; b.data = 32'd0;
      end
      beat_q.push_back(b);
    end
  endtask

  // Holds arvalid until accepted, then records the expected response.
  task automatic issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit hs = 0;
    int t  = 0;
    axi.araddr = addr; axi.arid = id; axi.arlen = len;
    axi.arsize = size; axi.arburst = burst; axi.arvalid = 1'b1;
    while (!hs && t < 300) begin
      @(negedge clk); hs = axi.arready;
      @(posedge clk); t++;
    end
    if (!hs) fail_now("ar_accept_timeout");
    else     push_expected(addr, id, len, size, burst);
    #1 axi.arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((beat_q.size() != 0 || maddr_q.size() != 0 || !axi.arready) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 3000) fail_now("drain_timeout");
  endtask

  task automatic wait_rvalid();
    int t = 0;
    while (!axi.rvalid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!axi.rvalid) fail_now("rvalid_timeout");
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       axi.rready = 1'b1;
      1:       axi.rready = ($urandom_range(0, 3) != 0);
      default: axi.rready = 1'b0;
    endcase
  end

  // Monitor: memory requests, R beats, stability under backpressure, AR gating.
  bit          have_prev = 0;
  logic [31:0] prev_data;
  logic [1:0]  prev_resp;
  logic        prev_last;
  logic [3:0]  prev_id;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 0;
    end else begin
      if (mem_en) begin
        if (maddr_q.size() == 0) fail_now("mem_en_unexpected");
        else check("mem_addr", mem_addr, maddr_q.pop_front());
      end
      if (have_prev) begin
        if (!axi.rvalid) fail_now("rvalid_dropped");
        else begin
          check("stable_rdata", axi.rdata, prev_data);
          check("stable_rresp", 32'(axi.rresp), 32'(prev_resp));
          check("stable_rlast", 32'(axi.rlast), 32'(prev_last));
          check("stable_rid",   32'(axi.rid),   32'(prev_id));
        end
      end
      have_prev = 0;
      if (axi.rvalid) begin
        if (axi.rready) begin
          beats_seen++;
          if (beat_q.size() == 0) fail_now("r_beat_unexpected");
          else begin
            beat_t e;
            e = beat_q.pop_front();
            check("rdata", axi.rdata, e.data);
            check("rresp", 32'(axi.rresp), 32'(e.resp));
            check("rlast", 32'(axi.rlast), 32'(e.last));
            check("rid",   32'(axi.rid),   32'(e.id));
          end
        end else begin
          have_prev = 1;
          prev_data = axi.rdata; prev_resp = axi.rresp;
          prev_last = axi.rlast; prev_id   = axi.rid;
        end
      end
      if (axi.arready) check("arready_while_busy", 32'(beat_q.size()), 32'd0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int b0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0;
    axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_arready", 32'(axi.arready), 32'd1);
    check("reset_rvalid",  32'(axi.rvalid),  32'd0);
    check("reset_rlast",   32'(axi.rlast),   32'd0);
    check("reset_rresp",   32'(axi.rresp),   32'd0);
    check("reset_rid",     32'(axi.rid),     32'd0);
    check("reset_rdata",   axi.rdata,        32'd0);
    check("reset_mem_en",  32'(mem_en),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR from the window base, with first-beat latency measurement.
    rdy_mode = 0;
    issue(BASE, 4'd1, 8'd3, 3'd2, AXI_BURST_INCR);
    cyc = 0;
    while (!axi.rvalid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("first_rvalid_latency", 32'(cyc), 32'd4);
    wait_drain();

    // WRAP around a 16-byte container, then FIXED.
    issue(BASE + 32'h38, 4'd2, 8'd3, 3'd2, AXI_BURST_WRAP);
    wait_drain();
    issue(BASE + 32'h38, 4'd3, 8'd2, 3'd2, AXI_BURST_FIXED);
    wait_drain();

    // Backpressure on the first beat for five cycles.
    rdy_mode = 2;
    issue(BASE + 32'h200, 4'd4, 8'd3, 3'd2, AXI_BURST_INCR);
    wait_rvalid();
    repeat (5) @(posedge clk);
    rdy_mode = 0;
    wait_drain();

    // Burst crossing the top of the window.
    issue(BASE + BYTES - 32'd4, 4'd6, 8'd1, 3'd2, AXI_BURST_INCR);
    wait_drain();

    // Reserved burst type, with a second request held during it.
    issue(BASE, 4'd5, 8'd1, 3'd2, 2'b11);
    issue(BASE + 32'h40, 4'd7, 8'd1, 3'd2, AXI_BURST_INCR);
    wait_drain();

    // Reset during beat 2 of 4 while rready is low.
    b0 = beats_seen;
    issue(BASE + 32'h100, 4'd3, 8'd3, 3'd2, AXI_BURST_INCR);
    cyc = 0;
    while (beats_seen < b0 + 1 && cyc < 100) begin
      @(posedge clk); cyc++;
    end
    rdy_mode = 2;
    @(posedge clk); #1;
    wait_rvalid();
    rst = 1'b1;
    beat_q.delete();
    maddr_q.delete();
    @(posedge clk); #1;
    check("midburst_reset_arready", 32'(axi.arready), 32'd1);
    check("midburst_reset_rvalid",  32'(axi.rvalid),  32'd0);
    rst = 1'b0;
    rdy_mode = 0;
    issue(BASE + 32'h300, 4'd9, 8'd2, 3'd2, AXI_BURST_INCR);
    wait_drain();

    // Randomized bursts around and across the window edges.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
      case ($urandom_range(0, 3))
        0:       a = BASE + $urandom_range(0, 4095);
        1:       a = BASE + BYTES - $urandom_range(1, 64);
        2:       a = BASE - $urandom_range(1, 64);
        default: a = $urandom;
      endcase
      len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rdy_mode = $urandom_range(0, 1);
      issue(a, 4'($urandom), len, size, 2'($urandom_range(0, 3)));
      wait_drain();
    end
    rdy_mode = 0;

    check("leftover_beats", 32'(beat_q.size()), 32'd0);
    check("leftover_mem",   32'(maddr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
